timer: RTL and testbench

- Two-digit BCD countdown timer for the DE1-SoC seven-segment display path.
- A one-clock `start` pulse loads a preset value and begins counting down. Count rate is one step per prescaled tick.
- Counts to 00 and then holds there with `done` asserted.
- Digit outputs feed external 7-segment decoders.

---
 rtl/timer.sv | 123 ++++++++++++
 tb/tb_timer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : timer
// Description : Two-digit BCD countdown timer. A start request loads a preset
//               and counts down once per prescaled tick, holding 00 with done.
// Revision    : 1.0 - initial release
// ============================================================================
module timer #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned START_TENS = 5,
    parameter int unsigned START_ONES = 9
) (
    input  logic       clk,
    output logic [3:0] ones_digit,
    output logic [3:0] tens_digits,
    input  logic       start,
    input  logic       reset,
    output logic       done
);

    // A divide of one still needs a one-bit prescaler so the compare stays legal.
    localparam int unsigned c_ps_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_ps_w-1:0] c_last_tick = c_ps_w'(TICK_DIV - 1);

    // Out-of-range presets saturate to 9 so the digits can never leave BCD.
    localparam logic [3:0] c_preset_tens = (START_TENS > 9) ? 4'd9 : 4'(START_TENS);
    localparam logic [3:0] c_preset_ones = (START_ONES > 9) ? 4'd9 : 4'(START_ONES);
    localparam logic       c_preset_zero = (c_preset_tens == 4'd0) && (c_preset_ones == 4'd0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_ps_w-1:0]  r_prescaler;

    logic [3:0] w_next_ones;
    logic [3:0] w_next_tens;
    logic       w_next_zero;
    logic       w_tick;

    assign w_tick = (r_prescaler == c_last_tick);

    // One BCD step down; 00 is a floor rather than wrapping to 99.
    always_comb begin
        w_next_ones = ones_digit;
        w_next_tens = tens_digits;
        if (ones_digit != 4'd0) begin
            w_next_ones = ones_digit - 4'd1;
        end else if (tens_digits != 4'd0) begin
            w_next_ones = 4'd9;
            w_next_tens = tens_digits - 4'd1;
        end
        w_next_zero = (w_next_ones == 4'd0) && (w_next_tens == 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            tens_digits <= c_preset_tens;
            ones_digit  <= c_preset_ones;
            done        <= 1'b0;
            r_prescaler <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    tens_digits <= c_preset_tens;
                    ones_digit  <= c_preset_ones;
                    done        <= 1'b0;
                    r_prescaler <= '0;
                    if (start) begin
                        if (c_preset_zero) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_tick) begin
                        r_prescaler <= '0;
                        ones_digit  <= w_next_ones;
                        tens_digits <= w_next_tens;
                        if (w_next_zero) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end
                    end else begin
                        r_prescaler <= r_prescaler + 1'b1;
                    end
                end

                ST_DONE: begin
                    done <= 1'b1;
                    if (start) begin
                        tens_digits <= c_preset_tens;
                        ones_digit  <= c_preset_ones;
                        r_prescaler <= '0;
                        if (!c_preset_zero) begin
                            r_state <= ST_RUN;
                            done    <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    tens_digits <= c_preset_tens;
                    ones_digit  <= c_preset_ones;
                    done        <= 1'b0;
                    r_prescaler <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_timer
// Description : Directed bench for timer with a scoreboard of expected digits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer;

    localparam int c_n = 5;

    logic           clk = 1'b0;
    logic [c_n-1:0] start_v;
    logic [c_n-1:0] reset_v;
    logic [3:0]     ones_v [c_n];
    logic [3:0]     tens_v [c_n];
    logic           done_v [c_n];

    always #5 clk = ~clk;

    timer #(.TICK_DIV(2)) u0 (
        .clk(clk), .ones_digit(ones_v[0]), .tens_digits(tens_v[0]),
        .start(start_v[0]), .reset(reset_v[0]), .done(done_v[0]));
    timer #(.TICK_DIV(2), .START_TENS(0), .START_ONES(3)) u1 (
        .clk(clk), .ones_digit(ones_v[1]), .tens_digits(tens_v[1]),
        .start(start_v[1]), .reset(reset_v[1]), .done(done_v[1]));
    timer #(.TICK_DIV(1), .START_TENS(1), .START_ONES(0)) u2 (
        .clk(clk), .ones_digit(ones_v[2]), .tens_digits(tens_v[2]),
        .start(start_v[2]), .reset(reset_v[2]), .done(done_v[2]));
    timer #(.TICK_DIV(2), .START_TENS(0), .START_ONES(5)) u3 (
        .clk(clk), .ones_digit(ones_v[3]), .tens_digits(tens_v[3]),
        .start(start_v[3]), .reset(reset_v[3]), .done(done_v[3]));
    timer #(.TICK_DIV(2), .START_TENS(0), .START_ONES(0)) u4 (
        .clk(clk), .ones_digit(ones_v[4]), .tens_digits(tens_v[4]),
        .start(start_v[4]), .reset(reset_v[4]), .done(done_v[4]));

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    // Value k edges after the start edge: preset minus whole ticks, floored at 00.
    function automatic exp_t model(input int p, input int td, input int k);
        exp_t e;
        int   v;
        v = p - (k / td);
        if (v < 0) v = 0;
        e.tens = 4'(v / 10);
        e.ones = 4'(v % 10);
        e.done = (v == 0);
        return e;
    endfunction

    task automatic check_pop(input int u, input string tag);
        exp_t e;
        exp_t obs;
        obs = {tens_v[u], ones_v[u], done_v[u]};
        n_total++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %0d%0d done=%0b",
                   tag, obs.tens, obs.ones, obs.done);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s u%0d: observed %0d%0d done=%0b, expected %0d%0d done=%0b",
                       tag, u, obs.tens, obs.ones, obs.done, e.tens, e.ones, e.done);
            end
        end
    endtask

    task automatic expect_now(input int u, input logic [3:0] t, input logic [3:0] o,
                              input logic d, input string tag);
        exp_t e;
        e.tens = t;
        e.ones = o;
        e.done = d;
        sb_q.push_back(e);
        check_pop(u, tag);
    endtask

    // Pulse start, then check ncyc edges; start is also raised at edge ign_k.
    task automatic countdown(input int u, input int p, input int td, input int ncyc,
                             input int ign_k, input string tag);
        for (int k = 0; k < ncyc; k++) sb_q.push_back(model(p, td, k));
        @(negedge clk);
        start_v[u] = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            check_pop(u, $sformatf("%s k%0d", tag, k));
            @(negedge clk);
            start_v[u] = (k + 1 == ign_k);
        end
        start_v[u] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        start_v = '0;
        reset_v = '1;

        @(posedge clk);
        #1;
        expect_now(0, 4'd5, 4'd9, 1'b0, "reset_u0");
        expect_now(3, 4'd0, 4'd5, 1'b0, "reset_u3");
        @(posedge clk);
        #1;
        expect_now(0, 4'd5, 4'd9, 1'b0, "reset_held");

        @(negedge clk);
        reset_v = '0;
        repeat (5) begin
            @(posedge clk);
            #1;
            expect_now(0, 4'd5, 4'd9, 1'b0, "idle_hold");
        end

        countdown(1, 3, 2, 10, -1, "basic");
        countdown(1, 3, 2, 8, -1, "restart");
        countdown(2, 10, 1, 13, -1, "borrow");
        countdown(3, 5, 2, 6, 3, "midrun_start");

        #2;
        reset_v[3] = 1'b1;
        #1;
        expect_now(3, 4'd0, 4'd5, 1'b0, "async_reset");
        @(negedge clk);
        reset_v[3] = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            expect_now(3, 4'd0, 4'd5, 1'b0, "post_reset_idle");
        end
        countdown(3, 5, 2, 12, -1, "after_reset");

        countdown(4, 0, 2, 4, -1, "zero");
        countdown(0, 59, 2, 122, -1, "full_default");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
